// File: rtl/arm_pkg.sv
// Shared encodings for the ARM pipeline: ALU operations, condition codes and the NZCV flag layout.
package arm_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORR = 4'd3,
        ALU_EOR = 4'd4,
        ALU_MOV = 4'd5,
        ALU_MVN = 4'd6,
        ALU_RSB = 4'd7
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam cond_e AL = COND_AL;

endpackage

// File: rtl/cond_unit.sv
// ARM condition check: decides whether the current instruction executes given the flags
// it sees (the flags register value from before this instruction).
import arm_pkg::*;

module cond_unit (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    flags_t f;
    assign f = flags_t'(flags);

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = f.z;
            COND_NE: cond_ex = ~f.z;
            COND_CS: cond_ex = f.c;
            COND_CC: cond_ex = ~f.c;
            COND_MI: cond_ex = f.n;
            COND_PL: cond_ex = ~f.n;
            COND_VS: cond_ex = f.v;
            COND_VC: cond_ex = ~f.v;
            COND_HI: cond_ex = f.c & ~f.z;
            COND_LS: cond_ex = ~f.c | f.z;
            COND_GE: cond_ex = (f.n == f.v);
            COND_LT: cond_ex = (f.n != f.v);
            COND_GT: cond_ex = ~f.z & (f.n == f.v);
            COND_LE: cond_ex = f.z | (f.n != f.v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, NZCV flags register, condition check, branch redirect and the
// execute->memory pipeline register.
import arm_pkg::*;

module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushM,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] RD3E,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUControlE,
    input  logic [1:0]       FlagWriteE,
    input  logic             ALUSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemToRegE,
    input  logic             BranchE,
    input  logic             PCSrcE,
    output logic [3:0]       FlagsE,
    output logic             BranchTakenE,
    output logic [WIDTH-1:0] BranchTargetE,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemToRegM,
    output logic             PCSrcM
);

    flags_t           flags_q, flags_d;
    logic             cond_ex;
    logic [WIDTH-1:0] src_a, src_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   wide;
    logic             alu_c, alu_v, op_valid;

    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;
    logic [3:0]       wa3_q, wa3_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             pc_src_q, pc_src_d;

    cond_unit u_cond_unit (
        .cond    (CondE),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign src_a = RD1E;
    assign src_b = ALUSrcE ? ExtImmE : RD2E;

    // Logic/move ops leave C and V at their old values, so they default to the register.
    always_comb begin
        wide     = '0;
        alu_res  = '0;
        alu_c    = flags_q.c;
        alu_v    = flags_q.v;
        op_valid = 1'b1;
        case (alu_op_e'(ALUControlE))
            ALU_ADD: begin
                wide    = {1'b0, src_a} + {1'b0, src_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                wide    = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_RSB: begin
                wide    = {1'b0, src_b} + {1'b0, ~src_a} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (src_b[WIDTH-1] != src_a[WIDTH-1]) && (alu_res[WIDTH-1] != src_b[WIDTH-1]);
            end
            ALU_AND: alu_res = src_a & src_b;
            ALU_ORR: alu_res = src_a | src_b;
            ALU_EOR: alu_res = src_a ^ src_b;
            ALU_MOV: alu_res = src_b;
            ALU_MVN: alu_res = ~src_b;
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (cond_ex && op_valid) begin
            if (FlagWriteE[1]) begin
                flags_d.n = alu_res[WIDTH-1];
                flags_d.z = (alu_res == '0);
            end
            if (FlagWriteE[0]) begin
                flags_d.c = alu_c;
                flags_d.v = alu_v;
            end
        end
    end

    // A flush loads a full bubble; a failed condition only clears the control bits.
    always_comb begin
        alu_result_d = alu_res;
        write_data_d = RD3E;
        wa3_d        = WA3E;
        reg_write_d  = RegWriteE & cond_ex;
        mem_write_d  = MemWriteE & cond_ex;
        mem_to_reg_d = MemToRegE & cond_ex;
        pc_src_d     = PCSrcE & cond_ex;
        if (FlushM) begin
            alu_result_d = '0;
            write_data_d = '0;
            wa3_d        = '0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            pc_src_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            wa3_q        <= wa3_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_src_q     <= pc_src_d;
        end
    end

    assign FlagsE        = flags_q;
    assign BranchTakenE  = BranchE & cond_ex;
    assign BranchTargetE = alu_res;
    assign ALUResultM    = alu_result_q;
    assign WriteDataM    = write_data_q;
    assign WA3M          = wa3_q;
    assign RegWriteM     = reg_write_q;
    assign MemWriteM     = mem_write_q;
    assign MemToRegM     = mem_to_reg_q;
    assign PCSrcM        = pc_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU results, flag updates, condition gating,
// branch redirect, flush and asynchronous reset.
module tb_execute_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         FlushM;
    logic [W-1:0] RD1E, RD2E, RD3E, ExtImmE;
    logic [3:0]   WA3E, CondE, ALUControlE;
    logic [1:0]   FlagWriteE;
    logic         ALUSrcE, RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE;
    logic [3:0]   FlagsE;
    logic         BranchTakenE;
    logic [W-1:0] BranchTargetE, ALUResultM, WriteDataM;
    logic [3:0]   WA3M;
    logic         RegWriteM, MemWriteM, MemToRegM, PCSrcM;

    int pass_cnt = 0;
    int total_cnt = 0;

    execute_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .FlushM        (FlushM),
        .RD1E          (RD1E),
        .RD2E          (RD2E),
        .RD3E          (RD3E),
        .ExtImmE       (ExtImmE),
        .WA3E          (WA3E),
        .CondE         (CondE),
        .ALUControlE   (ALUControlE),
        .FlagWriteE    (FlagWriteE),
        .ALUSrcE       (ALUSrcE),
        .RegWriteE     (RegWriteE),
        .MemWriteE     (MemWriteE),
        .MemToRegE     (MemToRegE),
        .BranchE       (BranchE),
        .PCSrcE        (PCSrcE),
        .FlagsE        (FlagsE),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .WA3M          (WA3M),
        .RegWriteM     (RegWriteM),
        .MemWriteM     (MemWriteM),
        .MemToRegM     (MemToRegM),
        .PCSrcM        (PCSrcM)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle_inputs();
        FlushM      = 1'b0;
        RD1E        = '0;
        RD2E        = '0;
        RD3E        = '0;
        ExtImmE     = '0;
        WA3E        = 4'd0;
        CondE       = 4'b1110;
        ALUControlE = 4'd0;
        FlagWriteE  = 2'b00;
        ALUSrcE     = 1'b0;
        RegWriteE   = 1'b0;
        MemWriteE   = 1'b0;
        MemToRegE   = 1'b0;
        BranchE     = 1'b0;
        PCSrcE      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (FlagsE !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", FlagsE);
        else pass_cnt++;
        total_cnt++;
        if ({RegWriteM, MemWriteM, MemToRegM, PCSrcM, WA3M} !== 8'h00 || ALUResultM !== '0 || WriteDataM !== '0)
            $display("FAIL reset_m: got ctl=%b wa3=%h alu=%h wd=%h expected all 0",
                     {RegWriteM, MemWriteM, MemToRegM, PCSrcM}, WA3M, ALUResultM, WriteDataM);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sub_zero();
        idle_inputs();
        RD1E = 32'd5; RD2E = 32'd5; ALUControlE = 4'd1; FlagWriteE = 2'b11;
        RegWriteE = 1'b1; WA3E = 4'd3; RD3E = 32'hDEAD_BEEF;
        step();
        total_cnt++;
        if (FlagsE !== 4'b0110) $display("FAIL sub_flags: got %b expected 0110", FlagsE);
        else pass_cnt++;
        total_cnt++;
        if (ALUResultM !== 32'h0 || RegWriteM !== 1'b1 || WA3M !== 4'd3 || WriteDataM !== 32'hDEAD_BEEF)
            $display("FAIL sub_m: got alu=%h rw=%b wa3=%h wd=%h expected 0 1 3 deadbeef",
                     ALUResultM, RegWriteM, WA3M, WriteDataM);
        else pass_cnt++;
    endtask

    task automatic test_add_overflow();
        idle_inputs();
        RD1E = 32'h7FFF_FFFF; ExtImmE = 32'd1; ALUSrcE = 1'b1; ALUControlE = 4'd0; FlagWriteE = 2'b11;
        step();
        total_cnt++;
        if (ALUResultM !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", ALUResultM);
        else pass_cnt++;
        total_cnt++;
        if (FlagsE !== 4'b1001) $display("FAIL add_flags: got %b expected 1001", FlagsE);
        else pass_cnt++;
    endtask

    task automatic test_cond_fail();
        idle_inputs();
        CondE = 4'b0000; RegWriteE = 1'b1; MemWriteE = 1'b1; FlagWriteE = 2'b11;
        step();
        total_cnt++;
        if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0)
            $display("FAIL cond_fail_ctl: got rw=%b mw=%b expected 0 0", RegWriteM, MemWriteM);
        else pass_cnt++;
        total_cnt++;
        if (FlagsE !== 4'b1001) $display("FAIL cond_fail_flags: got %b expected 1001", FlagsE);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        idle_inputs();
        BranchE = 1'b1; CondE = 4'b0001; RD1E = 32'h100; ExtImmE = 32'h20; ALUSrcE = 1'b1; PCSrcE = 1'b1;
        #1;
        total_cnt++;
        if (BranchTakenE !== 1'b1 || BranchTargetE !== 32'h120)
            $display("FAIL branch_ne: got taken=%b target=%h expected 1 120", BranchTakenE, BranchTargetE);
        else pass_cnt++;
        CondE = 4'b0000;
        #1;
        total_cnt++;
        if (BranchTakenE !== 1'b0) $display("FAIL branch_eq: got taken=%b expected 0", BranchTakenE);
        else pass_cnt++;
        CondE = 4'b1111;
        #1;
        total_cnt++;
        if (BranchTakenE !== 1'b0) $display("FAIL branch_never: got taken=%b expected 0", BranchTakenE);
        else pass_cnt++;
        CondE = 4'b0001;
        step();
        total_cnt++;
        if (PCSrcM !== 1'b1 || ALUResultM !== 32'h120)
            $display("FAIL branch_m: got pcsrc=%b alu=%h expected 1 120", PCSrcM, ALUResultM);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        idle_inputs();
        FlushM = 1'b1; RegWriteE = 1'b1; FlagWriteE = 2'b10; WA3E = 4'd7; RD3E = 32'h55;
        step();
        total_cnt++;
        if (RegWriteM !== 1'b0 || PCSrcM !== 1'b0 || WA3M !== 4'd0)
            $display("FAIL flush_m: got rw=%b pcsrc=%b wa3=%h expected 0 0 0", RegWriteM, PCSrcM, WA3M);
        else pass_cnt++;
        total_cnt++;
        if (FlagsE !== 4'b0101) $display("FAIL flush_flags: got %b expected 0101", FlagsE);
        else pass_cnt++;
    endtask

    task automatic test_logic_ops();
        idle_inputs();
        ALUControlE = 4'd7; RD1E = 32'd3; RD2E = 32'd5; FlagWriteE = 2'b11;
        step();
        total_cnt++;
        if (FlagsE !== 4'b0010 || ALUResultM !== 32'd2)
            $display("FAIL rsb: got flags=%b alu=%h expected 0010 2", FlagsE, ALUResultM);
        else pass_cnt++;
        ALUControlE = 4'd4; RD1E = 32'hFFFF_0000; RD2E = 32'h0000_FFFF;
        step();
        total_cnt++;
        if (FlagsE !== 4'b1010 || ALUResultM !== 32'hFFFF_FFFF)
            $display("FAIL eor_keep_cv: got flags=%b alu=%h expected 1010 ffffffff", FlagsE, ALUResultM);
        else pass_cnt++;
        ALUControlE = 4'd9; RD1E = 32'd1; RD2E = 32'd1;
        step();
        total_cnt++;
        if (FlagsE !== 4'b1010 || ALUResultM !== 32'h0)
            $display("FAIL reserved_op: got flags=%b alu=%h expected 1010 0", FlagsE, ALUResultM);
        else pass_cnt++;
    endtask

    // flags are now N=1 Z=0 C=1 V=0
    task automatic test_cond_codes();
        logic [3:0] conds [8];
        logic       exp_t [8];
        conds = '{4'b1010, 4'b1011, 4'b1000, 4'b1001, 4'b0100, 4'b0101, 4'b0010, 4'b0110};
        exp_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        idle_inputs();
        BranchE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            CondE = conds[i];
            #1;
            total_cnt++;
            if (BranchTakenE !== exp_t[i])
                $display("FAIL cond_%b: got taken=%b expected %b", conds[i], BranchTakenE, exp_t[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        ALUControlE = 4'd0; RD1E = 32'd1; RD2E = 32'd2; RegWriteE = 1'b1; WA3E = 4'd1;
        step();
        total_cnt++;
        if (ALUResultM !== 32'd3 || WA3M !== 4'd1) $display("FAIL b2b_add: got %h/%h expected 3/1", ALUResultM, WA3M);
        else pass_cnt++;
        ALUControlE = 4'd1; RD1E = 32'd10; RD2E = 32'd4; WA3E = 4'd2; MemToRegE = 1'b1;
        step();
        total_cnt++;
        if (ALUResultM !== 32'd6 || WA3M !== 4'd2 || MemToRegM !== 1'b1)
            $display("FAIL b2b_sub: got %h/%h/%b expected 6/2/1", ALUResultM, WA3M, MemToRegM);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        RegWriteE = 1'b1; ALUControlE = 4'd5; ExtImmE = 32'hABCD; ALUSrcE = 1'b1; FlagWriteE = 2'b11;
        step();
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (FlagsE !== 4'b0000 || RegWriteM !== 1'b0 || ALUResultM !== '0)
            $display("FAIL async_reset: got flags=%b rw=%b alu=%h expected 0000 0 0", FlagsE, RegWriteM, ALUResultM);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        test_reset();
        test_sub_zero();
        test_add_overflow();
        test_cond_fail();
        test_branch();
        test_flush();
        test_logic_ops();
        test_cond_codes();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
